// File: rtl/alu_exec_16.sv
// Execute/write-back stage for the 8x16 register file: IDLE -> EXEC -> WB, one write strobe per op.
// Optional 16-cycle shift-add multiply on op 111 when ALU_EXEC_MUL_EN is defined.
module alu_exec_16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] rd0_data,
  input  logic [15:0] rd1_data,
  input  logic [2:0]  dst_addr,
  output logic        busy,
  output logic        wr_en,
  output logic [2:0]  wr0_addr,
  output logic [15:0] wr0_data,
  output logic        flag_z,
  output logic        flag_c
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t      r_state;
  logic        r_ph;
  logic [2:0]  r_op;
  logic [2:0]  r_dst;
  logic [15:0] r_a;
  logic [15:0] r_b;
  logic [15:0] r_res;
  logic        r_cres;
  logic        r_wr_en;
  logic [2:0]  r_wr_addr;
  logic [15:0] r_wr_data;
  logic        r_flag_z;
  logic        r_flag_c;

  logic [15:0] w_alu_res;
  logic        w_alu_c;
  logic [3:0]  w_amt;
  logic [3:0]  w_shl_idx;

`ifdef ALU_EXEC_MUL_EN
  logic [3:0]  r_cnt;
  logic [31:0] r_mcand;
  logic [31:0] r_prod;
  logic [31:0] w_prod_next;

  assign w_prod_next = r_prod + (r_b[0] ? r_mcand : 32'd0);
`endif

  assign busy     = (r_state != S_IDLE);
  assign wr_en    = r_wr_en;
  assign wr0_addr = r_wr_addr;
  assign wr0_data = r_wr_data;
  assign flag_z   = r_flag_z;
  assign flag_c   = r_flag_c;

  // Shift-left carry is A[16-amt]; 4-bit wrap of (0 - amt) yields that index for amt 1..15.
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_amt     = r_b[3:0];
    w_shl_idx = 4'd0 - w_amt;
    case (r_op)
      3'b000: {w_alu_c, w_alu_res} = {1'b0, r_a} + {1'b0, r_b};
      3'b001: begin
        w_alu_res = r_a - r_b;
        w_alu_c   = (r_a < r_b);
      end
      3'b010: w_alu_res = r_a & r_b;
      3'b011: w_alu_res = r_a | r_b;
      3'b100: w_alu_res = r_a ^ r_b;
      3'b101: begin
        w_alu_res = r_a << w_amt;
        w_alu_c   = (w_amt != 4'd0) && r_a[w_shl_idx];
      end
      3'b110: begin
        w_alu_res = r_a >> w_amt;
        w_alu_c   = (w_amt != 4'd0) && r_a[w_amt - 4'd1];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ph      <= 1'b0;
      r_op      <= '0;
      r_dst     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_res     <= '0;
      r_cres    <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_flag_z  <= 1'b0;
      r_flag_c  <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      r_cnt     <= '0;
      r_mcand   <= '0;
      r_prod    <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_a     <= rd0_data;
            r_b     <= rd1_data;
            r_dst   <= dst_addr;
            r_ph    <= 1'b0;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          // First EXEC cycle registers the ALU result (and primes the multiplier).
          if (!r_ph) begin
            r_ph   <= 1'b1;
            r_res  <= w_alu_res;
            r_cres <= w_alu_c;
`ifdef ALU_EXEC_MUL_EN
            r_cnt   <= '0;
            r_prod  <= '0;
            r_mcand <= {16'd0, r_a};
`endif
          end else begin
`ifdef ALU_EXEC_MUL_EN
            if (r_op == 3'b111) begin
              r_prod  <= w_prod_next;
              r_mcand <= r_mcand << 1;
              r_b     <= r_b >> 1;
              r_cnt   <= r_cnt + 4'd1;
              if (r_cnt == 4'd15) begin
                r_wr_en   <= 1'b1;
                r_wr_addr <= r_dst;
                r_wr_data <= w_prod_next[15:0];
                r_flag_z  <= (w_prod_next[15:0] == 16'd0);
                r_flag_c  <= (w_prod_next[31:16] != 16'd0);
                r_state   <= S_WB;
              end
            end else begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_dst;
              r_wr_data <= r_res;
              r_flag_z  <= (r_res == 16'd0);
              r_flag_c  <= r_cres;
              r_state   <= S_WB;
            end
`else
            if (r_op != 3'b111) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_dst;
              r_wr_data <= r_res;
              r_flag_z  <= (r_res == 16'd0);
              r_flag_c  <= r_cres;
            end
            r_state <= S_WB;
`endif
          end
        end
        S_WB:    r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
